// File: rtl/logic_op_pkg.sv
// logic_op_pkg: shared types for the logic-op arbiter.
//   op_e    - 3-bit bitwise opcode (code 7 is illegal)
//   state_e - arbiter FSM state
package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// logic_op_unit: purely combinational bitwise opcode evaluator.
// Ports:
//   op  in  3      opcode (logic_op_pkg::op_e encoding)
//   a   in  WIDTH  operand a
//   b   in  WIDTH  operand b (ignored for NOT)
//   y   out WIDTH  result (0 for an illegal opcode)
//   err out 1      illegal opcode flag
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: begin
        y   = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin arbiter between two requesters sharing one
// bitwise logic unit. One operation is in flight at a time; the result is
// registered and held until the consumer handshakes it.
// Optional feature macro: LOGIC_ARB_STATS_EN adds saturating per-requester
// 16-bit grant counters (grant_cnt0, grant_cnt1).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   reqN_valid/ready           requester N handshake (ready is combinational)
//   reqN_op, reqN_a, reqN_b    requester N opcode and operands
//   res_valid/ready            result handshake
//   res_data, res_src, res_err registered result, source index, illegal-op flag
//   grant_cnt0/1               (LOGIC_ARB_STATS_EN only) accept counters
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_src,
  output logic             res_err
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e           state, next_state;
  logic             last_grant;
  logic             grant_p0;
  logic             accept_p0;
  logic [2:0]       op_p0;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [WIDTH-1:0] y_p0;
  logic             err_p0;
  logic [WIDTH-1:0] data_p1;
  logic             src_p1;
  logic             err_p1;

  // Stage p0: arbitration, grant mux and combinational evaluation
  always_comb begin
    grant_p0   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    next_state = state;
    // On a tie, the requester that did not win last time is granted.
    if (req0_valid && req1_valid) grant_p0 = ~last_grant;
    else if (req1_valid)          grant_p0 = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!rst) begin
          req0_ready = req0_valid && !grant_p0;
          req1_ready = req1_valid &&  grant_p0;
          if (req0_valid || req1_valid) next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (res_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign accept_p0 = req0_ready | req1_ready;
  assign op_p0     = grant_p0 ? req1_op : req0_op;
  assign a_p0      = grant_p0 ? req1_a  : req0_a;
  assign b_p0      = grant_p0 ? req1_b  : req0_b;

  logic_op_unit #(.WIDTH(WIDTH)) u_unit (
    .op  (op_p0),
    .a   (a_p0),
    .b   (b_p0),
    .y   (y_p0),
    .err (err_p0)
  );

  // Stage p1: FSM state and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= next_state;
      if (accept_p0) last_grant <= grant_p0;
    end
  end

  // Result registers are cleared by reset and otherwise change only on accept,
  // so they stay stable while waiting for res_ready and after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      src_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else if (accept_p0) begin
      data_p1 <= y_p0;
      src_p1  <= grant_p0;
      err_p1  <= err_p0;
    end
  end

  assign res_valid = (state == ST_BUSY);
  assign res_data  = data_p1;
  assign res_src   = src_p1;
  assign res_err   = err_p1;

`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      if (req0_ready) grant_cnt0 <= sat_inc16(grant_cnt0);
      if (req1_ready) grant_cnt1 <= sat_inc16(grant_cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
module tb_logic_op_arbiter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [2:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_src, res_err;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0]      grant_cnt0, grant_cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_op_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_src    (res_src),
    .res_err    (res_err)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one op from a single requester, then handshake it immediately.
  task automatic run_op(input int sel, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_d, input logic exp_e,
                        input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    if (sel == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    check({tag, "_rdy"}, {30'd0, req1_ready, req0_ready}, (sel == 0) ? 32'd1 : 32'd2);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check({tag, "_vld"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, res_data}, {24'd0, exp_d});
    check({tag, "_src"}, {31'd0, res_src}, sel[31:0]);
    check({tag, "_err"}, {31'd0, res_err}, {31'd0, exp_e});
    @(negedge clk);
    #1;
    check({tag, "_done"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = '0; req1_b = '0;

    // Reset state; readys must stay low while rst is high even with valid requests.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    #1;
    check("rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst_vld", {31'd0, res_valid}, 32'd0);
    check("rst_data", {24'd0, res_data}, 32'd0);
    check("rst_src", {31'd0, res_src}, 32'd0);
    check("rst_err", {31'd0, res_err}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // Single AND from requester 0.
    run_op(0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, "and0");

    // Both valid every cycle: grants alternate starting with requester 0.
    do_reset();
    res_ready = 1'b1;
    req0_op = 3'd0; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_op = 3'd1; req1_a = 8'h0F; req1_b = 8'h30;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_rdy", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      #1;
      check("rr_vld", {31'd0, res_valid}, 32'd1);
      check("rr_busy_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      check("rr_src", {31'd0, res_src}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_data", {24'd0, res_data}, (i % 2 == 0) ? 32'h30 : 32'h3F);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b0;

    // NOT from requester 1 held under backpressure.
    @(negedge clk);
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 8'hA5; req1_b = 8'h00;
    #1;
    check("not_rdy", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h11; req0_b = 8'h22;
    req1_a = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_vld", {31'd0, res_valid}, 32'd1);
      check("bp_data", {24'd0, res_data}, 32'h5A);
      check("bp_src", {31'd0, res_src}, 32'd1);
      check("bp_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_done", {31'd0, res_valid}, 32'd0);
    check("bp_hold", {24'd0, res_data}, 32'h5A);

    // Illegal opcode, then recovery with XNOR; then remaining opcodes.
    run_op(0, 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1, "ill");
    run_op(0, 3'd6, 8'h0F, 8'h0F, 8'hFF, 1'b0, "xnor");
    run_op(1, 3'd3, 8'hCC, 8'hAA, 8'h77, 1'b0, "nand");
    run_op(1, 3'd4, 8'hC0, 8'h0A, 8'h35, 1'b0, "nor");
    run_op(0, 3'd5, 8'hCC, 8'hAA, 8'h66, 1'b0, "xor");

    // Reset while a result is pending.
    @(negedge clk);
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h81; req0_b = 8'h18;
    @(negedge clk);
    #1;
    check("mid_vld", {31'd0, res_valid}, 32'd1);
    check("mid_data", {24'd0, res_data}, 32'h99);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("mid_rst_vld", {31'd0, res_valid}, 32'd0);
    check("mid_rst_data", {24'd0, res_data}, 32'd0);
`ifdef LOGIC_ARB_STATS_EN
    check("mid_rst_cnt0", {16'd0, grant_cnt0}, 32'd0);
    check("mid_rst_cnt1", {16'd0, grant_cnt1}, 32'd0);
`endif
    req0_valid = 1'b0;
    rst = 1'b0;

`ifdef LOGIC_ARB_STATS_EN
    for (int i = 0; i < 5; i++) run_op(0, 3'd0, 8'hFF, 8'h0F, 8'h0F, 1'b0, "cnt0");
    for (int i = 0; i < 3; i++) run_op(1, 3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0, "cnt1");
    check("cnt0", {16'd0, grant_cnt0}, 32'd5);
    check("cnt1", {16'd0, grant_cnt1}, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
